// File: rtl/dm_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dm_arbiter_ctrl_if
//  Brief    : CPU / debug / clear request bus and data-memory port bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface dm_arbiter_ctrl_if;
    logic        cpu_Req;
    logic        cpu_WriteEn;
    logic [31:0] cpu_Address;
    logic [31:0] cpu_Data;
    logic [31:0] cpu_PC;
    logic        cpu_Stall;
    logic [31:0] cpu_Rdata;

    logic        dbg_Req;
    logic        dbg_WriteEn;
    logic [31:0] dbg_Address;
    logic [31:0] dbg_Data;
    logic        dbg_Gnt;
    logic [31:0] dbg_Rdata;

    logic        clr_Start;
    logic        Busy;

    logic [31:0] dm_Address;
    logic [31:0] dm_Data;
    logic [31:0] dm_PC;
    logic        dm_WriteEn;
    logic [31:0] dm_Output;

    // Requesters plus the memory itself
    modport master (
        output cpu_Req, cpu_WriteEn, cpu_Address, cpu_Data, cpu_PC,
        output dbg_Req, dbg_WriteEn, dbg_Address, dbg_Data,
        output clr_Start, dm_Output,
        input  cpu_Stall, cpu_Rdata, dbg_Gnt, dbg_Rdata, Busy,
        input  dm_Address, dm_Data, dm_PC, dm_WriteEn
    );

    // The arbiter
    modport slave (
        input  cpu_Req, cpu_WriteEn, cpu_Address, cpu_Data, cpu_PC,
        input  dbg_Req, dbg_WriteEn, dbg_Address, dbg_Data,
        input  clr_Start, dm_Output,
        output cpu_Stall, cpu_Rdata, dbg_Gnt, dbg_Rdata, Busy,
        output dm_Address, dm_Data, dm_PC, dm_WriteEn
    );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dm_arbiter_ctrl
//  Brief    : Data-memory arbiter (CPU vs debug, anti-starvation) with clear
//             sequencer. Optional write trace: define DM_ARBITER_TRACE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module dm_arbiter_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             Reset,
    dm_arbiter_ctrl_if.slave bus
);
    localparam int                      c_STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0]       c_LAST_WORD  = '1;
    localparam logic [c_STARVE_W-1:0]   c_STARVE_LIM = c_STARVE_W'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  r_state,      w_state_nxt;
    logic [ADDR_W-1:0]       r_clr_cnt,    w_clr_cnt_nxt;
    logic [c_STARVE_W-1:0]   r_starve_cnt, w_starve_cnt_nxt;
    logic                    w_cpu_gnt,    w_dbg_gnt;
    logic                    w_busy,       w_dm_we;
    logic [31:0]             w_dm_addr,    w_dm_data, w_dm_pc;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= ST_CLEAR;
            r_clr_cnt    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_cnt    <= w_clr_cnt_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_clr_cnt_nxt    = r_clr_cnt;
        w_starve_cnt_nxt = r_starve_cnt;
        w_cpu_gnt        = 1'b0;
        w_dbg_gnt        = 1'b0;
        w_busy           = 1'b0;
        w_dm_we          = 1'b0;
        w_dm_addr        = bus.cpu_Address;
        w_dm_data        = bus.cpu_Data;
        w_dm_pc          = bus.cpu_PC;

        case (r_state)
            ST_CLEAR: begin
                w_busy        = 1'b1;
                w_dm_we       = 1'b1;
                w_dm_addr     = 32'({r_clr_cnt, 2'b00});
                w_dm_data     = '0;
                // Counter wraps to zero on the last word, ready for the next clear
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == c_LAST_WORD)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.cpu_Req && bus.dbg_Req) begin
                    if (r_starve_cnt == c_STARVE_LIM)
                        w_dbg_gnt = 1'b1;
                    else
                        w_cpu_gnt = 1'b1;
                end else begin
                    w_cpu_gnt = bus.cpu_Req;
                    w_dbg_gnt = bus.dbg_Req;
                end

                if (w_dbg_gnt) begin
                    w_dm_we   = bus.dbg_WriteEn;
                    w_dm_addr = bus.dbg_Address;
                    w_dm_data = bus.dbg_Data;
                    w_dm_pc   = 32'hFFFF_FFFF;
                end else if (w_cpu_gnt) begin
                    w_dm_we   = bus.cpu_WriteEn;
                end

                if (bus.clr_Start) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase

        // Counts denied debug cycles; any grant or idle debug port restarts it
        if (!bus.dbg_Req || w_dbg_gnt)
            w_starve_cnt_nxt = '0;
        else if (r_starve_cnt != c_STARVE_LIM)
            w_starve_cnt_nxt = r_starve_cnt + 1'b1;
    end

    assign bus.Busy       = w_busy;
    assign bus.dm_WriteEn = w_dm_we & Reset;
    assign bus.dm_Address = w_dm_addr;
    assign bus.dm_Data    = w_dm_data;
    assign bus.dm_PC      = w_dm_pc;
    assign bus.cpu_Stall  = bus.cpu_Req & ~w_cpu_gnt;
    assign bus.dbg_Gnt    = w_dbg_gnt;
    assign bus.cpu_Rdata  = bus.dm_Output;
    assign bus.dbg_Rdata  = bus.dm_Output;

`ifdef DM_ARBITER_TRACE_EN
    always @(posedge clk) begin
        if (Reset && (r_state == ST_RUN) && bus.dm_WriteEn)
            $display("@%08h: *%08h <= %08h", bus.dm_PC, bus.dm_Address, bus.dm_Data);
    end
`else
    // Trace disabled: nothing is built here.
`endif

endmodule
`default_nettype wire

// File: doc/dm_arbiter_ctrl.md
DM_ARBITER_CTRL -- requirements
Module: dm_arbiter_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address bits of the data memory; DEPTH = 2**ADDR_W words.
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning consecutive denied debug cycles before debug is forced a grant.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 cpu_Req  in  1  CPU MEM-stage access request.
REQ-006 cpu_WriteEn  in  1  CPU write (1) or read (0).
REQ-007 cpu_Address  in  32  CPU byte address; word index = cpu_Address[ADDR_W+1:2].
REQ-008 cpu_Data  in  32  CPU write data.
REQ-009 cpu_PC  in  32  PC of the CPU instruction, passed through for trace.
REQ-010 cpu_Stall  out  1  CPU access not granted this cycle; pipeline must hold.
REQ-011 dbg_Req, dbg_WriteEn  in  1 each  debug/loader port request and write flag.
REQ-012 dbg_Address, dbg_Data  in  32 each  debug byte address and write data.
REQ-013 dbg_Gnt  out  1  debug access granted this cycle.
REQ-014 clr_Start  in  1  request a full memory clear.
REQ-015 Busy  out  1  clear sequence in progress.
REQ-016 dm_Address, dm_Data, dm_PC  out  32 each  drive the data memory ports.
REQ-017 dm_WriteEn  out  1  data memory write enable.
REQ-018 dm_Output  in  32  data memory combinational read data.
REQ-019 cpu_Rdata, dbg_Rdata  out  32 each  read data returned to each requester.

Function
REQ-020 SHALL implement FSM states CLEAR and RUN.
REQ-021 CLEAR: dm_Address = {clr_cnt, 2'b00} zero-extended, dm_Data = 0, dm_WriteEn = 1, Busy = 1, cpu_Stall = cpu_Req, dbg_Gnt = 0.
REQ-022 CLEAR: clr_cnt (ADDR_W bits) increments every cycle; at clr_cnt = DEPTH-1 the next state is RUN and clr_cnt wraps to 0; clear takes exactly DEPTH cycles.
REQ-023 RUN, only one requester: that requester is granted the same cycle.
REQ-024 RUN, both requesting: CPU granted unless starve_cnt = STARVE_MAX, in which case debug is granted and cpu_Stall = 1 for that cycle.
REQ-025 starve_cnt increments on each cycle with dbg_Req=1 and dbg_Gnt=0, clears on any debug grant or dbg_Req=0, saturates at STARVE_MAX.
REQ-026 Granted requester's address/data/write flag (and cpu_PC, or 32'hFFFFFFFF for debug) drive dm_*; no grant: dm_WriteEn = 0, dm_Address = cpu_Address.
REQ-027 Reads are zero-latency: cpu_Rdata = dbg_Rdata = dm_Output combinationally; valid only in the granted cycle.
REQ-028 Writes commit at the rising edge ending the granted cycle.
REQ-029 clr_Start=1 in RUN: that cycle's grant proceeds normally, next state CLEAR with clr_cnt = 0; clr_Start during CLEAR is ignored (no restart).
REQ-030 cpu_Stall = cpu_Req AND NOT CPU-granted; never asserted without cpu_Req.

Reset
REQ-031 Reset low: state = CLEAR, clr_cnt = 0, starve_cnt = 0, immediately and independent of clk.
REQ-032 While Reset low: dm_WriteEn = 0, Busy = 1, dbg_Gnt = 0, cpu_Stall = cpu_Req.
REQ-033 Reset asserted mid-clear or mid-access aborts it; after release the clear restarts from word 0.

Configuration
REQ-034 Macro DM_ARBITER_TRACE_EN defined: on each rising edge in RUN with dm_WriteEn=1, print "@<dm_PC>: *<dm_Address> <= <dm_Data>" in 8-digit hex; clear writes are not printed.
REQ-035 Macro undefined: no trace statements compiled; all other behaviour identical.

Verification
REQ-036 Release Reset, no requests -> Busy=1 for exactly 1024 cycles writing 0 to words 0..1023, then RUN, Busy=0.
REQ-037 RUN, CPU write 0x0000_0010 <= 0xDEADBEEF, then CPU read 0x10 -> cpu_Stall=0 both cycles, cpu_Rdata=0xDEADBEEF.
REQ-038 RUN, cpu_Req and dbg_Req held high 10 cycles -> dbg_Gnt high in cycle 5 and cycle 10 only, cpu_Stall high in exactly those cycles.
REQ-039 cpu_Req=1 during CLEAR -> cpu_Stall=1 until first RUN cycle, dm_WriteEn carries only clear writes.
REQ-040 Reset pulsed low at clr_cnt=500 -> dm_WriteEn=0 immediately; after release clear restarts at word 0, 1024 cycles.
REQ-041 clr_Start in RUN after writing 0x55 to word 3 -> next 1024 cycles Busy=1; afterwards debug read of word 3 returns 0.
